// File: rtl/disp_median3x3_pkg.sv
// Shared constants for the 3x3 disparity median filter.
package disp_median3x3_pkg;

   localparam int unsigned DWIDTH_DEF  = 9;
   localparam int unsigned AWIDTH_DEF  = 11;
   localparam int unsigned MED_LAT     = 4;
   localparam int unsigned BYPASS_COLS = 2;

endpackage

// File: rtl/median_sort3.sv
// Combinational 3-input sorter; ties keep input order so outputs are always input values.
module median_sort3 #(
   parameter int unsigned W = 9
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  logic [W-1:0] c_i,
   output logic [W-1:0] min_o,
   output logic [W-1:0] med_o,
   output logic [W-1:0] max_o
);

   logic [W-1:0] lo_ab;
   logic [W-1:0] hi_ab;
   logic [W-1:0] lo_hc;

   // med = max(min(a,b), min(max(a,b), c))
   always_comb begin
      lo_ab = (a_i <= b_i) ? a_i : b_i;
      hi_ab = (a_i <= b_i) ? b_i : a_i;
      lo_hc = (hi_ab <= c_i) ? hi_ab : c_i;
      min_o = (lo_ab <= c_i) ? lo_ab : c_i;
      max_o = (hi_ab <= c_i) ? c_i : hi_ab;
      med_o = (lo_ab <= lo_hc) ? lo_hc : lo_ab;
   end

endmodule

// File: rtl/disp_median3x3.sv
// 3x3 median filter over a sliding column window; first two columns of a line bypass row1.
module disp_median3x3
   import disp_median3x3_pkg::*;
#(
   parameter int unsigned DWIDTH = DWIDTH_DEF,
   parameter int unsigned AWIDTH = AWIDTH_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clken,
   input  logic [AWIDTH-1:0] width,
   input  logic              in_valid,
   input  logic [DWIDTH-1:0] row0,
   input  logic [DWIDTH-1:0] row1,
   input  logic [DWIDTH-1:0] row2,
   output logic [DWIDTH-1:0] dout,
   output logic              valid
);

   localparam int unsigned NSTG = MED_LAT;

   typedef logic [DWIDTH-1:0] pix_t;
   typedef pix_t [2:0]        trio_t;

   logic              accept_c;
   logic              bypass_c;
   logic [AWIDTH-1:0] col_q, col_d;
   trio_t [2:0]       win_q;          // [column][row], column 0 oldest
   logic [NSTG-1:0]   vld_q;
   logic [NSTG-2:0]   byp_q;
   trio_t             mins_q, meds_q, maxs_q;
   pix_t              pix2_q, pix3_q;
   pix_t              lo3_q, mid3_q, hi3_q, dout_q;
   trio_t             s2_mn_c, s2_md_c, s2_mx_c;
   trio_t [2:0]       s3_in_c;
   trio_t             s3_mn_c, s3_md_c, s3_mx_c;
   pix_t              s4_mn_c, s4_md_c, s4_mx_c;
   logic              sort_unused;

   assign accept_c = clken & in_valid;
   assign bypass_c = (col_q < AWIDTH'(BYPASS_COLS)) || (width <= AWIDTH'(BYPASS_COLS));

   always_comb begin
      col_d = col_q + AWIDTH'(1);
      if (col_q >= width - AWIDTH'(1)) col_d = '0;
   end

   // S2: sort each window column; S3: max of mins, med of meds, min of maxes; S4: final median
   assign s3_in_c = {maxs_q, meds_q, mins_q};

   for (genvar k = 0; k < 3; k++) begin : g_sort
      median_sort3 #(.W(DWIDTH)) u_col (
         .a_i(win_q[k][0]), .b_i(win_q[k][1]), .c_i(win_q[k][2]),
         .min_o(s2_mn_c[k]), .med_o(s2_md_c[k]), .max_o(s2_mx_c[k])
      );
      median_sort3 #(.W(DWIDTH)) u_mix (
         .a_i(s3_in_c[k][0]), .b_i(s3_in_c[k][1]), .c_i(s3_in_c[k][2]),
         .min_o(s3_mn_c[k]), .med_o(s3_md_c[k]), .max_o(s3_mx_c[k])
      );
   end

   median_sort3 #(.W(DWIDTH)) u_final (
      .a_i(lo3_q), .b_i(mid3_q), .c_i(hi3_q),
      .min_o(s4_mn_c), .med_o(s4_md_c), .max_o(s4_mx_c)
   );

   assign sort_unused = ^{s3_mn_c[1:0], s3_md_c[2], s3_md_c[0], s3_mx_c[2:1], s4_mn_c, s4_mx_c};

   // Flags shift every enabled edge; data stages load only behind a valid token
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         col_q  <= '0;
         win_q  <= '0;
         vld_q  <= '0;
         byp_q  <= '0;
         mins_q <= '0;
         meds_q <= '0;
         maxs_q <= '0;
         pix2_q <= '0;
         pix3_q <= '0;
         lo3_q  <= '0;
         mid3_q <= '0;
         hi3_q  <= '0;
         dout_q <= '0;
      end else if (clken) begin
         vld_q <= {vld_q[NSTG-2:0], in_valid};
         byp_q <= {byp_q[NSTG-3:0], bypass_c};
         if (accept_c) begin
            win_q <= {{row2, row1, row0}, win_q[2], win_q[1]};
            col_q <= col_d;
         end
         if (vld_q[0]) begin
            mins_q <= s2_mn_c;
            meds_q <= s2_md_c;
            maxs_q <= s2_mx_c;
            pix2_q <= win_q[2][1];
         end
         if (vld_q[1]) begin
            lo3_q  <= s3_mx_c[0];
            mid3_q <= s3_md_c[1];
            hi3_q  <= s3_mn_c[2];
            pix3_q <= pix2_q;
         end
         if (vld_q[2]) dout_q <= byp_q[2] ? pix3_q : s4_md_c;
      end
   end

   assign dout  = dout_q;
   assign valid = vld_q[NSTG-1];

endmodule

// File: tb/tb_disp_median3x3.sv
// Directed and random checks of disp_median3x3 against a sort-based line model.
module tb_disp_median3x3;

   localparam int unsigned DW = disp_median3x3_pkg::DWIDTH_DEF;
   localparam int unsigned AW = disp_median3x3_pkg::AWIDTH_DEF;

   logic          clk = 1'b0;
   logic          rst;
   logic          clken;
   logic [AW-1:0] width;
   logic          in_valid;
   logic [DW-1:0] row0, row1, row2;
   logic [DW-1:0] dout;
   logic          valid;

   int n_assert = 0;
   int n_fail   = 0;
   int model_w;
   int edge_cnt = 0;
   int exp_q[$];
   int acc_edge_q[$];
   int cap_q[$];
   int ln0[$], ln1[$], ln2[$];
   logic [DW-1:0] prev_dout;
   logic          prev_valid;

   disp_median3x3 dut (
      .clk(clk), .rst(rst), .clken(clken), .width(width), .in_valid(in_valid),
      .row0(row0), .row1(row1), .row2(row2), .dout(dout), .valid(valid)
   );

   initial forever #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   // Reference: keep the current line's columns and take the 5th of 9 sorted pixels
   task automatic model_accept(input int r0, input int r1, input int r2);
      int win[$];
      int c;
      int res;
      ln0.push_back(r0); ln1.push_back(r1); ln2.push_back(r2);
      c = ln1.size() - 1;
      if (c < 2 || model_w < 3) res = r1;
      else begin
         for (int k = c - 2; k <= c; k++) begin
            win.push_back(ln0[k]); win.push_back(ln1[k]); win.push_back(ln2[k]);
         end
         win.sort();
         res = win[4];
      end
      exp_q.push_back(res);
      acc_edge_q.push_back(edge_cnt);
      if (ln1.size() >= model_w) begin
         ln0.delete(); ln1.delete(); ln2.delete();
      end
   endtask

   task automatic step(input bit ce, input bit iv, input int r0, input int r1, input int r2);
      int e, a;
      clken = ce; in_valid = iv;
      row0 = DW'(r0); row1 = DW'(r1); row2 = DW'(r2);
      if (ce && iv) model_accept(r0, r1, r2);
      @(posedge clk); #1;
      if (ce) begin
         edge_cnt++;
         if (valid === 1'b1) begin
            if (exp_q.size() == 0) check("spurious_valid", 32'(valid), 32'd0);
            else begin
               e = exp_q.pop_front();
               a = acc_edge_q.pop_front();
               check("dout", 32'(dout), 32'(e));
               check("latency", 32'(edge_cnt - 1 - a), 32'd3);
               cap_q.push_back(int'(dout));
            end
         end
      end else begin
         check("freeze_valid", 32'(valid), 32'(prev_valid));
         check("freeze_dout", 32'(dout), 32'(prev_dout));
      end
      prev_valid = valid;
      prev_dout  = dout;
   endtask

   task automatic drain();
      repeat (8) step(1'b1, 1'b0, 0, 0, 0);
      check("pending_outputs", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      #1;
      check("rst_valid", 32'(valid), 32'd0);
      check("rst_dout", 32'(dout), 32'd0);
      exp_q.delete(); acc_edge_q.delete(); cap_q.delete();
      ln0.delete(); ln1.delete(); ln2.delete();
      @(posedge clk); #1;
      rst = 1'b1;
      prev_valid = valid;
      prev_dout  = dout;
   endtask

   task automatic set_width(input int w);
      width   = AW'(w);
      model_w = w;
   endtask

   initial begin
      int t0[4], t1[4], t2[4], e30[4];
      int r1s[$];
      int n_acc;
      int v;
      rst = 1'b0; clken = 1'b0; in_valid = 1'b0;
      row0 = '0; row1 = '0; row2 = '0;
      set_width(8);
      do_reset();

      // Flat field, width 8
      for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 5, 5, 5);
      drain();
      check("flat_count", 32'(cap_q.size()), 32'd8);
      foreach (cap_q[i]) check("flat_value", 32'(cap_q[i]), 32'd5);

      // Hand-computed line, width 4
      do_reset();
      set_width(4);
      t0 = '{1, 9, 4, 0}; t1 = '{2, 8, 6, 0}; t2 = '{3, 7, 5, 0}; e30 = '{2, 8, 5, 5};
      for (int i = 0; i < 4; i++) step(1'b1, 1'b1, t0[i], t1[i], t2[i]);
      drain();
      check("w4_count", 32'(cap_q.size()), 32'd4);
      for (int i = 0; i < 4 && i < cap_q.size(); i++) check("w4_value", 32'(cap_q[i]), 32'(e30[i]));

      // Alternating bubbles, width 6
      do_reset();
      set_width(6);
      for (int i = 0; i < 24; i++)
         step(1'b1, (i % 2) == 0, $urandom_range(0, 511), $urandom_range(0, 511), $urandom_range(0, 511));
      drain();
      check("bubble_count", 32'(cap_q.size()), 32'd12);

      // Three-cycle stall mid-stream, width 8
      do_reset();
      set_width(8);
      for (int i = 0; i < 16; i++) begin
         if (i == 6) repeat (3) step(1'b0, 1'b1, 1, 2, 3);
         step(1'b1, 1'b1, $urandom_range(0, 511), $urandom_range(0, 511), $urandom_range(0, 511));
      end
      drain();
      check("stall_count", 32'(cap_q.size()), 32'd16);

      // Reset at col=3 with data in flight
      do_reset();
      set_width(8);
      step(1'b1, 1'b1, 1, 10, 1);
      step(1'b1, 1'b1, 2, 20, 2);
      step(1'b1, 1'b1, 3, 30, 3);
      step(1'b1, 1'b0, 0, 0, 0);
      check("pre_rst_valid", 32'(valid), 32'd1);
      do_reset();
      step(1'b1, 1'b1, 7, 77, 7);
      drain();
      check("post_rst_count", 32'(cap_q.size()), 32'd1);
      if (cap_q.size() > 0) check("post_rst_bypass", 32'(cap_q[0]), 32'd77);

      // Width 2: every output is row1
      do_reset();
      set_width(2);
      for (int i = 0; i < 10; i++) begin
         v = $urandom_range(0, 511);
         r1s.push_back(v);
         step(1'b1, 1'b1, $urandom_range(0, 511), v, $urandom_range(0, 511));
      end
      drain();
      check("w2_count", 32'(cap_q.size()), 32'd10);
      for (int i = 0; i < 10 && i < cap_q.size(); i++) check("w2_bypass", 32'(cap_q[i]), 32'(r1s[i]));

      // Random traffic at width 1920 with narrow-range pixels for ties, bubbles and stalls
      do_reset();
      set_width(1920);
      n_acc = 0;
      for (int i = 0; i < 500; i++) begin
         bit ce, iv;
         int hi;
         ce = ($urandom_range(0, 9) != 0);
         iv = ($urandom_range(0, 5) != 0);
         hi = (i % 3 == 0) ? 7 : 511;
         if (ce && iv) n_acc++;
         step(ce, iv, $urandom_range(0, hi), $urandom_range(0, hi), $urandom_range(0, hi));
      end
      drain();
      check("random_count", 32'(cap_q.size()), 32'(n_acc));

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
